multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with single-cycle add/sub/logic ops, an iterative
// shift-add multiplier and an optional iterative restoring divider.
//
// Optional feature: define ALU_DIV_EN to build the divider (opcode 0011). Without it,
// opcode 0011 behaves as add and DivZero is tied low.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   firstInput, secondInput  operands A and B (captured on accept)
//   operation                opcode: 0000 add, 0001 sub, 0010 mul, 0011 div,
//                            1000 and, 1001 or, 1010 xor, others add
//   inValid / inReady        request handshake (ready only while idle)
//   outValid / outReady      result handshake (valid only while done)
//   ALU_Out                  registered result
//   CarryOut, Zero, Negative, Overflow, DivZero  registered flags
module multicycle_alu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] firstInput,
  input  logic [WIDTH-1:0] secondInput,
  input  logic [3:0]       operation,
  input  logic             inValid,
  output logic             inReady,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             DivZero
);

  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpMul = 4'b0010;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OpDiv = 4'b0011;
`endif
  localparam logic [3:0] OpAnd = 4'b1000;
  localparam logic [3:0] OpOr  = 4'b1001;
  localparam logic [3:0] OpXor = 4'b1010;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // mul: acc = partial product, opa = multiplier (shifts right), opb = multiplicand
  // div: opa = dividend shifting out / quotient shifting in, opb = divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  // Per-cycle iteration results and the value to commit when entering StDone
  logic [WIDTH-1:0] acc_step, opa_step, res_n;
  logic             carry_n, ovf_n, commit;
  logic [WIDTH:0]   sum, diff;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, rem_step;
  logic [WIDTH:0]   rem_shift, rem_trial;
  logic             dz_q, dz_d, dz_n;
`endif

  assign sum  = {1'b0, firstInput} + {1'b0, secondInput};
  assign diff = {1'b0, firstInput} - {1'b0, secondInput};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    res_n    = '0;
    carry_n  = 1'b0;
    ovf_n    = 1'b0;
    commit   = 1'b0;
    acc_step = opa_q[0] ? acc_q + opb_q : acc_q;
    opa_step = opa_q >> 1;
`ifdef ALU_DIV_EN
    rem_d     = rem_q;
    dz_d      = dz_q;
    dz_n      = 1'b0;
    rem_shift = {rem_q, opa_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opb_q};
    rem_step  = rem_shift[WIDTH-1:0];
    if (is_div_q) begin
      if (rem_shift >= {1'b0, opb_q}) begin
        rem_step = rem_trial[WIDTH-1:0];
        opa_step = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        opa_step = {opa_q[WIDTH-2:0], 1'b0};
      end
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (inValid) begin
          commit = 1'b1;
          case (operation)
            OpSub: begin
              res_n   = diff[WIDTH-1:0];
              carry_n = ~diff[WIDTH];
              ovf_n   = (firstInput[WIDTH-1] != secondInput[WIDTH-1]) &&
                        (diff[WIDTH-1] != firstInput[WIDTH-1]);
            end
            OpMul: begin
              commit   = 1'b0;
              state_d  = StBusy;
              cnt_d    = '0;
              is_div_d = 1'b0;
              acc_d    = '0;
              opa_d    = secondInput;
              opb_d    = firstInput;
            end
`ifdef ALU_DIV_EN
            OpDiv: begin
              if (secondInput == '0) begin
                res_n = '1;
                dz_n  = 1'b1;
              end else begin
                commit   = 1'b0;
                state_d  = StBusy;
                cnt_d    = '0;
                is_div_d = 1'b1;
                rem_d    = '0;
                opa_d    = firstInput;
                opb_d    = secondInput;
              end
            end
`endif
            OpAnd: res_n = firstInput & secondInput;
            OpOr:  res_n = firstInput | secondInput;
            OpXor: res_n = firstInput ^ secondInput;
            default: begin
              res_n   = sum[WIDTH-1:0];
              carry_n = sum[WIDTH];
              ovf_n   = (firstInput[WIDTH-1] == secondInput[WIDTH-1]) &&
                        (sum[WIDTH-1] != firstInput[WIDTH-1]);
            end
          endcase
        end
      end
      StBusy: begin
        acc_d = acc_step;
        opa_d = opa_step;
        opb_d = is_div_q ? opb_q : opb_q << 1;
        cnt_d = cnt_q + 1'b1;
`ifdef ALU_DIV_EN
        rem_d = rem_step;
`endif
        // The last iteration's result goes straight to the output register
        if (cnt_q == CntLast) begin
          commit = 1'b1;
          res_n  = is_div_q ? opa_step : acc_step;
        end
      end
      StDone: begin
        if (outReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      state_d = StDone;
      res_d   = res_n;
      carry_d = carry_n;
      ovf_d   = ovf_n;
      zero_d  = (res_n == '0);
      neg_d   = res_n[WIDTH-1];
`ifdef ALU_DIV_EN
      dz_d    = dz_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_DIV_EN
      rem_q    <= '0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`ifdef ALU_DIV_EN
      rem_q    <= rem_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign inReady  = (state_q == StIdle);
  assign outValid = (state_q == StDone);
  assign ALU_Out  = res_q;
  assign CarryOut = carry_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;
`ifdef ALU_DIV_EN
  assign DivZero  = dz_q;
`else
  assign DivZero  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=64). Expected results come from a
// behavioural model, are queued when a request is driven and checked when the DUT
// presents outValid.
module tb_multicycle_alu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] first_input, second_input;
  logic [3:0]   operation;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] alu_out;
  logic         carry_out, zero, negative, overflow, div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, n, v, dz;
    int           lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .firstInput (first_input),
    .secondInput(second_input),
    .operation  (operation),
    .inValid    (in_valid),
    .inReady    (in_ready),
    .outValid   (out_valid),
    .outReady   (out_ready),
    .ALU_Out    (alu_out),
    .CarryOut   (carry_out),
    .Zero       (zero),
    .Negative   (negative),
    .Overflow   (overflow),
    .DivZero    (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op);
    exp_t e;
    logic [W:0] s;
    logic signed [W:0] ss;
    e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      4'b0001: begin
        e.res = a - b;
        e.c   = (a >= b);
        ss    = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.v   = ss[W] != ss[W-1];
      end
      4'b0010: begin e.res = a * b; e.lat = W + 1; end
`ifdef ALU_DIV_EN
      4'b0011: begin
        if (b == 0) begin e.res = '1; e.dz = 1'b1; end
        else begin e.res = a / b; e.lat = W + 1; end
      end
`endif
      4'b1000: e.res = a & b;
      4'b1001: e.res = a | b;
      4'b1010: e.res = a ^ b;
      default: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c   = s[W];
        ss    = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.v   = ss[W] != ss[W-1];
      end
    endcase
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // Issue one request, wait for the result, compare, hold for `hold` cycles with stray
  // inValid pulses, then release with outReady while also offering a new request.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input int hold);
    exp_t e;
    int   cyc;
    sb.push_back(model(a, b, op));
    @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    first_input = a; second_input = b; operation = op; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    first_input = {$urandom, $urandom}; second_input = {$urandom, $urandom};
    operation = 4'b1001;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      if (in_ready) check("in_ready_busy", {63'd0, in_ready}, 64'd0);
      in_valid = cyc[0];
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("result", alu_out, e.res);
    check("carry", {63'd0, carry_out}, {63'd0, e.c});
    check("zero", {63'd0, zero}, {63'd0, e.z});
    check("negative", {63'd0, negative}, {63'd0, e.n});
    check("overflow", {63'd0, overflow}, {63'd0, e.v});
    check("divzero", {63'd0, div_zero}, {63'd0, e.dz});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", alu_out, e.res);
    end
    // New request on the release edge must not be taken
    out_ready = 1'b1; in_valid = 1'b1; operation = 4'b0000;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd0);
    check("release_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    first_input = '0; second_input = '0; operation = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_alu_out", alu_out, 64'd0);
    check("rst_flags", {59'd0, carry_out, zero, negative, overflow, div_zero}, 64'd0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 4'b0001, 0);
    run_op(64'd3, 64'd5, 4'b0001, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 0);
    run_op(64'h1234, 64'h10, 4'b0010, 0);
    run_op(64'hDEAD_BEEF_0123_4567, 64'h0000_0001_0000_0003, 4'b0010, 0);
    run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b1010, 10);
    run_op(64'hF0F0, 64'h0F0F, 4'b1000, 0);
    run_op(64'hF0F0, 64'h0F0F, 4'b1001, 0);
    run_op(64'd40, 64'd2, 4'b0111, 0);
    run_op(64'd100, 64'd7, 4'b0011, 0);
    run_op(64'd5, 64'd0, 4'b0011, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'b0011, 0);

    // Reset during a multiply aborts it; reset wins over a simultaneous request
    @(negedge clk);
    first_input = 64'h55; second_input = 64'h77; operation = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("midmul_busy", {63'd0, in_ready}, 64'd0);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_alu_out", alu_out, 64'd0);
    run_op(64'd2, 64'd3, 4'b0000, 0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
